i2s_frame_ctrl: RTL



---
 rtl/ctrl_pkg.sv | 34 +++
 rtl/ws_bit_counter.sv | 48 ++++
 rtl/i2s_frame_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : ctrl_pkg
// Purpose : Shared control-register types and I2S frame controller constants.
// Rev     : 1.0  initial release
// ============================================================================
package ctrl_pkg;

    typedef enum logic {
        f16bits = 1'b0,
        f32bits = 1'b1
    } frame_size_t;

    typedef struct packed {
        frame_size_t frame_size;
        logic        stop;
        logic        mute;
    } OP_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEAD = 2'd1,
        RUN  = 2'd2
    } i2s_fsm_t;

    localparam int W16 = 16;
    localparam int W32 = 32;

    function automatic logic [5:0] word_width(input frame_size_t fs);
        return (fs == f16bits) ? 6'(W16) : 6'(W32);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ws_bit_counter.sv
`default_nettype none
// ============================================================================
// Module  : ws_bit_counter
// Purpose : Bit down-counter with reload and word-select toggle at bit 1.
// Rev     : 1.0  initial release
// ============================================================================
module ws_bit_counter (
    input  logic       clk,
    input  logic       rst_,
    input  logic       i_cnt_load,
    input  logic       i_cnt_en,
    input  logic       i_ws_set,
    input  logic       i_ws_clr,
    input  logic [4:0] i_load_val,
    output logic [4:0] o_bit_cnt,
    output logic       o_ws
);

    logic [4:0] r_bit_cnt;
    logic       r_ws;

    always_ff @(negedge clk or negedge rst_) begin
        if (!rst_) begin
            r_bit_cnt <= 5'd31;
            r_ws      <= 1'b1;
        end else begin
            if (i_cnt_load) begin
                r_bit_cnt <= i_load_val;
            end else if (i_cnt_en) begin
                r_bit_cnt <= (r_bit_cnt == 5'd0) ? i_load_val : r_bit_cnt - 5'd1;
            end

            // ws changes one SCK ahead of the next word's MSB
            if (i_ws_set) begin
                r_ws <= 1'b1;
            end else if (i_ws_clr) begin
                r_ws <= 1'b0;
            end else if (i_cnt_en && (r_bit_cnt == 5'd1)) begin
                r_ws <= ~r_ws;
            end
        end
    end

    assign o_bit_cnt = r_bit_cnt;
    assign o_ws      = r_ws;

endmodule
`default_nettype wire

// File: rtl/i2s_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : i2s_frame_ctrl
// Purpose : I2S transmit frame controller (ws, rd_en, bit/frame position).
//           Define I2S_UNDERRUN_EN to build the sticky underrun detector.
// Rev     : 1.0  initial release
// ============================================================================
module i2s_frame_ctrl
    import ctrl_pkg::*;
#(
    parameter int FRAME_W = 16
) (
    input  logic               clk,
    input  logic               rst_,
    input  OP_t                OP,
    input  logic               start,
    input  logic               fifo_empty,
    output logic               ws,
    output logic               rd_en,
    output logic [4:0]         bit_cnt,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               busy,
    output logic               underrun,
    input  logic               underrun_clr
);

    i2s_fsm_t           r_state;
    i2s_fsm_t           w_next;
    logic [5:0]         r_w_lat;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic [4:0]         w_cur_m1;
    logic [4:0]         w_lat_m1;
    logic [4:0]         w_load_val;
    logic               w_cnt_load;
    logic               w_cnt_en;
    logic               w_ws_set;
    logic               w_ws_clr;
    logic               w_frame_inc;
    logic               w_frame_end;
    logic               w_unused;

    assign w_cur_m1 = 5'(word_width(OP.frame_size) - 6'd1);
    assign w_lat_m1 = 5'(r_w_lat - 6'd1);

    // At bit_cnt==0 ws already shows the next word, so ws==0 marks the right word's last bit
    assign w_frame_end = (r_state == RUN) && (bit_cnt == 5'd0) && !ws;

    always_ff @(negedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_load_val  = w_lat_m1;
        w_cnt_load  = 1'b0;
        w_cnt_en    = 1'b0;
        w_ws_set    = 1'b0;
        w_ws_clr    = 1'b0;
        w_frame_inc = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_load = 1'b1;
                w_load_val = w_cur_m1;
                if (start && !OP.stop && !fifo_empty) begin
                    w_next   = LEAD;
                    w_ws_clr = 1'b1;
                end else begin
                    w_ws_set = 1'b1;
                end
            end
            LEAD: begin
                if (OP.stop) begin
                    w_next     = IDLE;
                    w_cnt_load = 1'b1;
                    w_ws_set   = 1'b1;
                end else begin
                    w_next = RUN;
                end
            end
            RUN: begin
                if (OP.stop) begin
                    w_next     = IDLE;
                    w_cnt_load = 1'b1;
                    w_ws_set   = 1'b1;
                end else if (w_frame_end) begin
                    w_frame_inc = 1'b1;
                    if (!start) begin
                        w_next     = IDLE;
                        w_cnt_load = 1'b1;
                        w_ws_set   = 1'b1;
                    end else begin
                        w_cnt_en = 1'b1;
                    end
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(negedge clk or negedge rst_) begin
        if (!rst_) begin
            r_w_lat     <= 6'(W32);
            r_frame_cnt <= '0;
        end else begin
            if (r_state == IDLE) begin
                r_w_lat <= word_width(OP.frame_size);
            end
            if (w_frame_inc) begin
                r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
            end
        end
    end

    ws_bit_counter u_ws_bit_counter (
        .clk        (clk),
        .rst_       (rst_),
        .i_cnt_load (w_cnt_load),
        .i_cnt_en   (w_cnt_en),
        .i_ws_set   (w_ws_set),
        .i_ws_clr   (w_ws_clr),
        .i_load_val (w_load_val),
        .o_bit_cnt  (bit_cnt),
        .o_ws       (ws)
    );

    assign rd_en     = (r_state == RUN);
    assign busy      = (r_state != IDLE);
    assign frame_cnt = r_frame_cnt;

`ifdef I2S_UNDERRUN_EN
    logic w_ur_set;
    logic r_underrun;

    assign w_ur_set = (r_state == RUN) && (bit_cnt == w_lat_m1) && fifo_empty;

    always_ff @(negedge clk or negedge rst_) begin
        if (!rst_) begin
            r_underrun <= 1'b0;
        end else if (w_ur_set) begin
            r_underrun <= 1'b1;
        end else if (underrun_clr) begin
            r_underrun <= 1'b0;
        end
    end

    assign underrun = r_underrun;
    assign w_unused = OP.mute;
`else
    assign underrun = 1'b0;
    assign w_unused = OP.mute ^ underrun_clr;
`endif

endmodule
`default_nettype wire
